// File: rtl/sr_pkg.sv
// Shared types for the SR bank driver: FSM state encoding and per-bit SR command codes.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // {s, r} command codes for one flop
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_BAD  = 2'b11;

  // Never yields SR_BAD: a differing bit is either set or reset, never both.
  function automatic logic [1:0] sr_code(input logic tgt_bit, input logic diff_bit);
    if (!diff_bit) return SR_HOLD;
    return tgt_bit ? SR_SET : SR_RST;
  endfunction

endpackage

// File: rtl/sr_drv_cnt.sv
// Loadable down-counter with a zero flag; saturates at zero so it can never wrap.
module sr_drv_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sr_bank_driver.sv
// Drives a bank of SR flops toward a requested word with set/reset pulses, then
// waits for the q feedback to match or a timeout to expire, and reports the outcome.
module sr_bank_driver
  import sr_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int PULSE_CYCLES = 1,
  parameter int TIMEOUT      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] mismatch
);

  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] P_LOAD = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] tgt_reg;
  logic [WIDTH-1:0] diff, s_load, r_load;
  logic             accept, match, timeout;
  logic             p_load, p_dec, p_zero;
  logic             t_load, t_dec, t_zero;

  assign diff    = tgt_data ^ q_fb;
  assign accept  = tgt_valid & tgt_ready;
  assign match   = (q_fb == tgt_reg);
  assign timeout = ~match & t_zero;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_code
      assign {s_load[gi], r_load[gi]} = sr_code(tgt_data[gi], diff[gi]);
    end
  endgenerate

  // Pulse counter runs PULSE_CYCLES-1 .. 0; settle counter runs TIMEOUT-1 .. 0.
  assign p_load = accept;
  assign p_dec  = (state_reg == PULSE);
  assign t_load = (state_reg == PULSE) & p_zero;
  assign t_dec  = (state_reg == SETTLE);

  sr_drv_cnt #(.W(PW)) u_pcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (p_load),
    .load_val (P_LOAD),
    .dec      (p_dec),
    .zero     (p_zero)
  );

  sr_drv_cnt #(.W(TW)) u_tcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (T_LOAD),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = (diff == '0) ? DONE : PULSE;
      end
      PULSE: begin
        if (abort)       state_next = IDLE;
        else if (p_zero) state_next = SETTLE;
      end
      SETTLE: begin
        if (abort)                  state_next = IDLE;
        else if (match || timeout)  state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tgt_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_reg)
      IDLE: begin
        tgt_ready = ~abort;
        busy      = 1'b0;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // s/r are loaded only from disjoint masks and cleared on every exit from PULSE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s        <= '0;
      r        <= '0;
      tgt_reg  <= '0;
      err      <= 1'b0;
      mismatch <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            tgt_reg  <= tgt_data;
            s        <= s_load;
            r        <= r_load;
            err      <= 1'b0;
            mismatch <= '0;
          end
        end
        PULSE: begin
          if (abort || p_zero) begin
            s <= '0;
            r <= '0;
          end
        end
        SETTLE: begin
          if (!abort && timeout) begin
            err      <= 1'b1;
            mismatch <= q_fb ^ tgt_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_bank_driver.sv
// Bench for sr_bank_driver: directed vector table, abort/reset sequences, and random
// operations checked against an outcome model of a registered SR bank with stuck bits.
module tb_sr_bank_driver;

  localparam int W = 8;
  localparam int P = 1;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         abort = 1'b0;
  logic         tgt_valid = 1'b0;
  logic [W-1:0] tgt_data = '0;
  logic         tgt_ready;
  logic [W-1:0] q_fb;
  logic [W-1:0] s, r, mismatch;
  logic         busy, done, err;

  logic [W-1:0] bank = '0;
  logic [W-1:0] stuck0 = '0;
  logic [W-1:0] stuck1 = '0;
  logic [W-1:0] preset_val = '0;
  logic         preset_en = 1'b0;

  int tests = 0;
  int fails = 0;

  sr_bank_driver #(.WIDTH(W), .PULSE_CYCLES(P), .TIMEOUT(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .tgt_valid (tgt_valid),
    .tgt_data  (tgt_data),
    .tgt_ready (tgt_ready),
    .q_fb      (q_fb),
    .s         (s),
    .r         (r),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mismatch  (mismatch)
  );

  always #5 clk = ~clk;

  // Bank of SR flops; stuck masks model broken cells.
  always @(posedge clk) begin
    if (preset_en) bank <= (preset_val & ~stuck0) | stuck1;
    else           bank <= (((bank & ~r) | s) & ~stuck0) | stuck1;
  end
  assign q_fb = bank;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected outcome of one operation from the bank's initial value.
  function automatic void model(input logic [W-1:0] q0, input logic [W-1:0] tgt,
                                input logic [W-1:0] st0, input logic [W-1:0] st1,
                                output int lat, output logic e, output logic [W-1:0] mis,
                                output logic [W-1:0] sx, output logic [W-1:0] rx);
    logic [W-1:0] d, fin;
    d  = tgt ^ q0;
    sx = tgt & d;
    rx = ~tgt & d;
    if (d == '0) begin
      lat = 1; e = 1'b0; mis = '0;
    end else begin
      fin = (((q0 & ~rx) | sx) & ~st0) | st1;
      if (fin == tgt) begin
        lat = P + 2; e = 1'b0; mis = '0;
      end else begin
        lat = P + T + 1; e = 1'b1; mis = fin ^ tgt;
      end
    end
  endfunction

  // Presets the bank and offers tgt; returns at the negedge of the cycle after the accept edge.
  task automatic start_op(input logic [W-1:0] q0, input logic [W-1:0] st0,
                          input logic [W-1:0] st1, input logic [W-1:0] tgt);
    stuck0 = st0; stuck1 = st1; preset_val = q0; preset_en = 1'b1;
    step();
    preset_en = 1'b0;
    tgt_valid = 1'b1; tgt_data = tgt;
    step();
    tgt_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] q0, input logic [W-1:0] tgt,
                        input logic [W-1:0] st0, input logic [W-1:0] st1, input int lat,
                        input logic e, input logic [W-1:0] mis, input logic [W-1:0] sx,
                        input logic [W-1:0] rx);
    int c;
    bit got, clash;
    logic [W-1:0] so, ro;
    stuck0 = st0; stuck1 = st1; preset_val = q0; preset_en = 1'b1;
    step();
    preset_en = 1'b0;
    check({tag, " ready"}, tgt_ready, 1'b1);
    tgt_valid = 1'b1; tgt_data = tgt;
    step();
    tgt_valid = 1'b0;
    so = '0; ro = '0; got = 0; clash = 0; c = 1;
    while (c <= 20) begin
      so |= s; ro |= r;
      if ((s & r) != '0) clash = 1;
      if (done) begin got = 1; break; end
      step();
      c++;
    end
    check({tag, " latency"}, got ? c : 0, lat);
    check({tag, " err"}, err, e);
    check({tag, " mismatch"}, mismatch, mis);
    check({tag, " s_seen"}, so, sx);
    check({tag, " r_seen"}, ro, rx);
    check({tag, " s_and_r"}, clash, 1'b0);
    step();
    check({tag, " done_one_cycle"}, done, 1'b0);
    check({tag, " err_held"}, err, e);
    check({tag, " mismatch_held"}, mismatch, mis);
    check({tag, " bank"}, bank, tgt ^ mis);
    $display("[TB] op %s q0=%02h tgt=%02h lat=%0d err=%0b mismatch=%02h", tag, q0, tgt, c, err, mismatch);
  endtask

  task automatic expect_quiet(input string name, input int n);
    bit seen;
    seen = 0;
    repeat (n) begin
      if (done) seen = 1;
      step();
    end
    check(name, seen, 1'b0);
  endtask

  typedef struct {
    logic [W-1:0] q0, tgt, st0, st1;
    int           lat;
    logic         e;
    logic [W-1:0] mis, sx, rx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [W-1:0] q0, qa, tgt, st0, st1, mis, sx, rx;
    int lat;
    logic e;

    vecs[0] = '{8'h00, 8'hA5, 8'h00, 8'h00, 3, 1'b0, 8'h00, 8'hA5, 8'h00};
    vecs[1] = '{8'hFF, 8'h0F, 8'h00, 8'h00, 3, 1'b0, 8'h00, 8'h00, 8'hF0};
    vecs[2] = '{8'h3C, 8'h3C, 8'h00, 8'h00, 1, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{8'h00, 8'h01, 8'h01, 8'h00, 6, 1'b1, 8'h01, 8'h01, 8'h00};
    vecs[4] = '{8'hF0, 8'h0F, 8'h00, 8'h00, 3, 1'b0, 8'h00, 8'h0F, 8'hF0};
    vecs[5] = '{8'h80, 8'h00, 8'h00, 8'h80, 6, 1'b1, 8'h80, 8'h00, 8'h80};

    #1;
    check("reset s", s, 8'h00);
    check("reset r", r, 8'h00);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset err", err, 1'b0);
    check("reset mismatch", mismatch, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post reset ready", tgt_ready, 1'b1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].q0, vecs[i].tgt, vecs[i].st0, vecs[i].st1,
             vecs[i].lat, vecs[i].e, vecs[i].mis, vecs[i].sx, vecs[i].rx);
    end

    // abort with tgt_valid in IDLE: refused, status from the timed-out op untouched
    abort = 1'b1; tgt_valid = 1'b1; tgt_data = 8'h5A;
    #1 check("idle_abort ready", tgt_ready, 1'b0);
    step();
    check("idle_abort busy", busy, 1'b0);
    check("idle_abort s", s, 8'h00);
    check("idle_abort r", r, 8'h00);
    check("idle_abort err", err, 1'b1);
    check("idle_abort mismatch", mismatch, 8'h80);
    abort = 1'b0; tgt_valid = 1'b0;
    $display("[TB] op idle_abort tgt=5A refused");
    expect_quiet("idle_abort no_done", 4);

    // abort in the first SETTLE cycle
    start_op(8'h00, 8'h01, 8'h00, 8'h01);
    step();
    check("settle_abort busy_before", busy, 1'b1);
    abort = 1'b1;
    step();
    check("settle_abort done", done, 1'b0);
    check("settle_abort busy", busy, 1'b0);
    abort = 1'b0;
    #1 check("settle_abort ready", tgt_ready, 1'b1);
    expect_quiet("settle_abort no_done", 8);
    $display("[TB] op settle_abort tgt=01 cancelled");

    // abort coincident with the timeout decision
    start_op(8'h00, 8'h01, 8'h00, 8'h01);
    repeat (T) step();
    check("timeout_abort busy_before", busy, 1'b1);
    abort = 1'b1;
    step();
    check("timeout_abort done", done, 1'b0);
    check("timeout_abort err", err, 1'b0);
    check("timeout_abort mismatch", mismatch, 8'h00);
    abort = 1'b0;
    expect_quiet("timeout_abort no_done", 8);
    $display("[TB] op timeout_abort tgt=01 cancelled");

    // async reset while pulsing
    start_op(8'h00, 8'h00, 8'h00, 8'h0F);
    check("rst_pulse s_before", s, 8'h0F);
    check("rst_pulse r_before", r, 8'h00);
    #1 rst_n = 1'b0;
    #1;
    check("rst_pulse s", s, 8'h00);
    check("rst_pulse r", r, 8'h00);
    check("rst_pulse busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_pulse ready", tgt_ready, 1'b1);
    check("rst_pulse err", err, 1'b0);
    check("rst_pulse done", done, 1'b0);
    $display("[TB] op rst_pulse tgt=0F reset mid-pulse");
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      q0 = W'($urandom);
      tgt = W'($urandom);
      st0 = '0; st1 = '0;
      if ($urandom_range(3) == 0) st0 = W'(1) << $urandom_range(W - 1);
      if ($urandom_range(3) == 0) st1 = (W'(1) << $urandom_range(W - 1)) & ~st0;
      qa = (q0 & ~st0) | st1;
      if ($urandom_range(4) == 0) tgt = qa;
      model(qa, tgt, st0, st1, lat, e, mis, sx, rx);
      run_op($sformatf("rnd%0d", i), q0, tgt, st0, st1, lat, e, mis, sx, rx);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
